// File: rtl/dvl_hb_pkg.sv
// Shared types and constants for the DVL H-bridge burst generator.
// Leg patterns are ordered {hlh, hll, hrh, hrl}.
package dvl_hb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEAD  = 3'd1,
        POS   = 3'd2,
        NEG   = 3'd3,
        DAMP  = 3'd4,
        FINAL = 3'd5
    } hb_state_t;

    localparam logic [3:0] HB_OFF  = 4'b0000;
    localparam logic [3:0] HB_POS  = 4'b1001;
    localparam logic [3:0] HB_NEG  = 4'b0110;
    localparam logic [3:0] HB_DAMP = 4'b0101;

    function automatic logic [31:0] max1(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/hb_output_stage.sv
// One bridge's gate-drive register: applies the per-channel POS/NEG swap and
// registers the four pins so no input reaches a gate combinationally.
module hb_output_stage
    import dvl_hb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] pat_i,
    input  logic       inv_i,
    output logic       hlh_o,
    output logic       hll_o,
    output logic       hrh_o,
    output logic       hrl_o
);

    logic [3:0] pins_d;
    logic [3:0] pins_q;

    always_comb begin
        pins_d = pat_i;
        if (inv_i && (pat_i == HB_POS)) begin
            pins_d = HB_NEG;
        end else if (inv_i && (pat_i == HB_NEG)) begin
            pins_d = HB_POS;
        end else begin
            pins_d = pat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pins_q <= 4'b0000;
        end else begin
            pins_q <= pins_d;
        end
    end

    // A high and low switch on the same leg must never conduct together.
    always_comb begin
        assert (!(pins_q[3] && pins_q[2]) && !(pins_q[1] && pins_q[0]));
    end

    assign {hlh_o, hll_o, hrh_o, hrl_o} = pins_q;

endmodule

// File: rtl/hbridge_burst_gen.sv
// Multi-channel transmit burst generator: dead-time separated POS/NEG drive,
// optional low-side damping, abort to a timed all-off, start/busy/done handshake.
module hbridge_burst_gen
    import dvl_hb_pkg::*;
#(
    parameter int NUM_CH = 1,
    parameter int DIV_W  = 16,
    parameter int DEAD_W = 8,
    parameter int CYC_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DIV_W-1:0]  half_period,
    input  logic [DEAD_W-1:0] dead_time,
    input  logic [CYC_W-1:0]  num_cycles,
    input  logic [DIV_W-1:0]  damp_cycles,
    input  logic [NUM_CH-1:0] ch_invert,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] hlh,
    output logic [NUM_CH-1:0] hll,
    output logic [NUM_CH-1:0] hrh,
    output logic [NUM_CH-1:0] hrl
);

    localparam int PH_W = (DIV_W > DEAD_W) ? DIV_W : DEAD_W;

    hb_state_t         state_q, state_d;
    hb_state_t         nxt_q, nxt_d;
    logic [PH_W-1:0]   cnt_q, cnt_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [DIV_W-1:0]  h_q, h_d;
    logic [DIV_W-1:0]  m_q, m_d;
    logic [DEAD_W-1:0] dt_q, dt_d;
    logic [CYC_W-1:0]  n_q, n_d;
    logic [NUM_CH-1:0] inv_q, inv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              launch_q, launch_d;
    logic [3:0]        pat_s;

    // A start on the done cycle is captured and launched after one idle cycle.
    always_comb begin
        state_d  = state_q;
        nxt_d    = nxt_q;
        cnt_d    = cnt_q;
        cyc_d    = cyc_q;
        h_d      = h_q;
        dt_d     = dt_q;
        n_d      = n_q;
        m_d      = m_q;
        inv_d    = inv_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        launch_d = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start && !launch_q) begin
                    h_d   = DIV_W'(max1(32'(half_period)));
                    dt_d  = DEAD_W'(max1(32'(dead_time)));
                    n_d   = num_cycles;
                    m_d   = damp_cycles;
                    inv_d = ch_invert;
                end else begin
                    inv_d = inv_q;
                end
                if (launch_q || (start && !done_q)) begin
                    if (n_d == {CYC_W{1'b0}}) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = DEAD;
                        cnt_d   = PH_W'(dt_d);
                        cyc_d   = n_d;
                        nxt_d   = POS;
                        busy_d  = 1'b1;
                    end
                end else if (start) begin
                    launch_d = 1'b1;
                end else begin
                    launch_d = 1'b0;
                end
            end
            DEAD: begin
                if (cnt_q == PH_W'(1)) begin
                    case (nxt_q)
                        POS, NEG: begin
                            state_d = nxt_q;
                            cnt_d   = PH_W'(h_q);
                        end
                        DAMP: begin
                            state_d = DAMP;
                            cnt_d   = PH_W'(m_q);
                        end
                        default: begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - PH_W'(1);
                end
            end
            POS: begin
                if (cnt_q == PH_W'(1)) begin
                    state_d = DEAD;
                    cnt_d   = PH_W'(dt_q);
                    nxt_d   = NEG;
                end else begin
                    cnt_d = cnt_q - PH_W'(1);
                end
            end
            NEG: begin
                if (cnt_q == PH_W'(1)) begin
                    state_d = DEAD;
                    cnt_d   = PH_W'(dt_q);
                    if (cyc_q > CYC_W'(1)) begin
                        nxt_d = POS;
                        cyc_d = cyc_q - CYC_W'(1);
                    end else if (m_q != {DIV_W{1'b0}}) begin
                        nxt_d = DAMP;
                    end else begin
                        nxt_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - PH_W'(1);
                end
            end
            DAMP, FINAL: begin
                if (cnt_q == PH_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - PH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (abort && ((state_q == DEAD) || (state_q == POS) ||
                      (state_q == NEG)  || (state_q == DAMP))) begin
            state_d = FINAL;
            cnt_d   = PH_W'(dt_q);
            nxt_d   = IDLE;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else begin
            done_d = done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            nxt_q    <= IDLE;
            cnt_q    <= {PH_W{1'b0}};
            cyc_q    <= {CYC_W{1'b0}};
            h_q      <= {DIV_W{1'b0}};
            dt_q     <= {DEAD_W{1'b0}};
            n_q      <= {CYC_W{1'b0}};
            m_q      <= {DIV_W{1'b0}};
            inv_q    <= {NUM_CH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            launch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            nxt_q    <= nxt_d;
            cnt_q    <= cnt_d;
            cyc_q    <= cyc_d;
            h_q      <= h_d;
            dt_q     <= dt_d;
            n_q      <= n_d;
            m_q      <= m_d;
            inv_q    <= inv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            launch_q <= launch_d;
        end
    end

    // Pattern follows the next state so the registered pins line up with state_q.
    always_comb begin
        pat_s = HB_OFF;
        case (state_d)
            POS:     pat_s = HB_POS;
            NEG:     pat_s = HB_NEG;
            DAMP:    pat_s = HB_DAMP;
            default: pat_s = HB_OFF;
        endcase
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        hb_output_stage u_stage (
            .clk   (clk),
            .reset (reset),
            .pat_i (pat_s),
            .inv_i (inv_q[i]),
            .hlh_o (hlh[i]),
            .hll_o (hll[i]),
            .hrh_o (hrh[i]),
            .hrl_o (hrl[i])
        );
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_hbridge_burst_gen.sv
// Bench for hbridge_burst_gen (2 channels): directed handshake/timing cases then a
// random run, all compared cycle by cycle against a queue-based schedule model.
module tb_hbridge_burst_gen;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [15:0] half_period, damp_cycles;
    logic [7:0]  dead_time;
    logic [11:0] num_cycles;
    logic [1:0]  ch_invert;
    logic        busy, done;
    logic [1:0]  hlh, hll, hrh, hrl;

    always #5 clk = ~clk;

    hbridge_burst_gen #(.NUM_CH(2), .DIV_W(16), .DEAD_W(8), .CYC_W(12)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .half_period(half_period), .dead_time(dead_time), .num_cycles(num_cycles),
        .damp_cycles(damp_cycles), .ch_invert(ch_invert), .busy(busy), .done(done),
        .hlh(hlh), .hll(hll), .hrh(hrh), .hrl(hrl)
    );

    localparam logic [1:0] P_OFF = 2'd0, P_POS = 2'd1, P_NEG = 2'd2, P_DAMP = 2'd3;

    typedef struct packed {
        logic [1:0] ph;
        logic       busy;
        logic       done;
        logic       ab_ok;
        logic [1:0] inv;
    } rec_t;

    rec_t       q[$];
    rec_t       cur;
    bit         pend;
    int         lh, ld, ln, lm;
    logic [1:0] linv;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic rec_t mk(input logic [1:0] ph, input logic b, input logic d, input logic a);
        rec_t r;
        r.ph = ph; r.busy = b; r.done = d; r.ab_ok = a; r.inv = linv;
        return r;
    endfunction

    function automatic logic [7:0] exp_pins(input rec_t r);
        logic [1:0] a, b, c, d, ph;
        logic [3:0] p;
        for (int ch = 0; ch < 2; ch++) begin
            ph = r.ph;
            if (r.inv[ch] && ph == P_POS) ph = P_NEG;
            else if (r.inv[ch] && ph == P_NEG) ph = P_POS;
            case (ph)
                P_POS:   p = 4'b1001;
                P_NEG:   p = 4'b0110;
                P_DAMP:  p = 4'b0101;
                default: p = 4'b0000;
            endcase
            a[ch] = p[3]; b[ch] = p[2]; c[ch] = p[1]; d[ch] = p[0];
        end
        return {a, b, c, d};
    endfunction

    task automatic build_burst();
        q.delete();
        if (ln == 0) begin
            q.push_back(mk(P_OFF, 1'b0, 1'b1, 1'b0));
        end else begin
            for (int i = 0; i < ld; i++) q.push_back(mk(P_OFF, 1'b1, 1'b0, 1'b1));
            for (int n = 0; n < ln; n++) begin
                for (int i = 0; i < lh; i++) q.push_back(mk(P_POS, 1'b1, 1'b0, 1'b1));
                for (int i = 0; i < ld; i++) q.push_back(mk(P_OFF, 1'b1, 1'b0, 1'b1));
                for (int i = 0; i < lh; i++) q.push_back(mk(P_NEG, 1'b1, 1'b0, 1'b1));
                for (int i = 0; i < ld; i++) q.push_back(mk(P_OFF, 1'b1, 1'b0, 1'b1));
            end
            for (int i = 0; i < lm; i++) q.push_back(mk(P_DAMP, 1'b1, 1'b0, 1'b1));
            q.push_back(mk(P_OFF, 1'b0, 1'b1, 1'b0));
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input bit st, input bit ab, input bit rs);
        rec_t nxt;
        start = st; abort = ab; reset = rs;
        if (rs) begin
            q.delete(); pend = 1'b0; nxt = '0;
        end else if (cur.busy && cur.ab_ok && ab) begin
            q.delete();
            for (int i = 1; i < ld; i++) q.push_back(mk(P_OFF, 1'b1, 1'b0, 1'b0));
            q.push_back(mk(P_OFF, 1'b0, 1'b1, 1'b0));
            nxt = mk(P_OFF, 1'b1, 1'b0, 1'b0);
        end else if (!cur.busy && pend) begin
            pend = 1'b0; build_burst(); nxt = q.pop_front();
        end else if (!cur.busy && st) begin
            lh = (half_period == 16'd0) ? 1 : int'(half_period);
            ld = (dead_time == 8'd0) ? 1 : int'(dead_time);
            ln = int'(num_cycles);
            lm = int'(damp_cycles);
            linv = ch_invert;
            if (cur.done) begin
                pend = 1'b1; nxt = '0;
            end else begin
                build_burst(); nxt = q.pop_front();
            end
        end else if (q.size() > 0) begin
            nxt = q.pop_front();
        end else begin
            nxt = '0;
        end
        @(posedge clk);
        #1;
        cur = nxt;
        start = 1'b0; abort = 1'b0; reset = 1'b0;
        check("pins", {hlh, hll, hrh, hrl}, exp_pins(nxt));
        check("busy", busy, nxt.busy);
        check("done", done, nxt.done);
        check("shoot", (hlh & hll) | (hrh & hrl), 2'b00);
    endtask

    task automatic set_cfg(input int h, input int d, input int n, input int m, input logic [1:0] inv);
        half_period = 16'(h); dead_time = 8'(d); num_cycles = 12'(n);
        damp_cycles = 16'(m); ch_invert = inv;
    endtask

    task automatic run_until_done(input int budget, output int k_done);
        k_done = -1;
        for (int k = 1; k <= budget; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (done) begin
                k_done = k;
                break;
            end
        end
    endtask

    initial begin
        int k;
        cur = '0; pend = 1'b0; linv = 2'b00; lh = 1; ld = 1; ln = 0; lm = 0;
        start = 1'b0; abort = 1'b0; reset = 1'b1;
        set_cfg(4, 2, 3, 0, 2'b00);

        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Timing: first POS at t+3, done at t+39.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("first_pos", {hlh, hll, hrh, hrl}, 8'hC3);
        run_until_done(200, k);
        check("lat_timing", k + 3, 39);
        step(1'b0, 1'b0, 1'b0);

        // Damping with zero clamps: done at t+1+1+4+5.
        set_cfg(0, 0, 1, 5, 2'b00);
        step(1'b1, 1'b0, 1'b0);
        run_until_done(100, k);
        check("lat_damp", k + 1, 11);
        step(1'b0, 1'b0, 1'b0);

        // Abort in the second NEG (cycle t+22).
        set_cfg(4, 2, 3, 0, 2'b00);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 2; i <= 22; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("abort_off", {hlh, hll, hrh, hrl}, 8'h00);
        run_until_done(50, k);
        check("abort_lat", k, 2);
        step(1'b0, 1'b0, 1'b0);

        // Inversion on channel 1 only.
        set_cfg(2, 1, 2, 1, 2'b10);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("inv_pos", {hlh, hll, hrh, hrl}, 8'h69);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        check("inv_neg", {hlh, hll, hrh, hrl}, 8'h96);
        run_until_done(100, k);
        step(1'b0, 1'b0, 1'b0);

        // N=0: no drive, done next cycle.
        set_cfg(3, 1, 0, 2, 2'b00);
        step(1'b1, 1'b0, 1'b0);
        check("n0_done", done, 1'b1);
        check("n0_busy", busy, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Start (with other config) during a burst is ignored.
        set_cfg(4, 2, 3, 0, 2'b00);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        set_cfg(1, 1, 1, 0, 2'b11);
        step(1'b1, 1'b0, 1'b0);
        run_until_done(200, k);
        check("ignore_lat", k + 6, 39);

        // Start on the done cycle: first POS at done+2+D.
        set_cfg(1, 1, 1, 0, 2'b00);
        step(1'b1, 1'b0, 1'b0);
        check("b2b_idle", busy, 1'b0);
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if ((hlh | hrh) != 2'b00) begin
                k = i;
                break;
            end
        end
        check("b2b_pos", k + 1, 3);
        run_until_done(50, k);
        step(1'b0, 1'b0, 1'b0);

        // Reset during POS: immediate all-off, no done.
        set_cfg(4, 2, 3, 0, 2'b00);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("rst_pins", {hlh, hll, hrh, hrl}, 8'h00);
        check("rst_busy", busy, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);

        // Random run with config churn, starts, aborts and rare resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                set_cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)));
            step($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 399) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
